mmc_operand_sequencer: RTL

- Upstream control stage of the 32x32 matrix-multiply core.
- Walks the (i, j, k) loop nest and issues read addresses to the A and B operand SRAMs, so that DO_A/DO_B arrive at the MAC one cycle later.
- Drives the MAC's counter0 input so each 21-bit accumulation restarts on the first term of every dot product.
- Issues a write strobe and address for result memory C exactly when the MAC's mul_out holds a completed sum.

---
 rtl/mmc_operand_sequencer_if.sv | 25 ++
 rtl/mmc_operand_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mmc_operand_sequencer_if.sv
// Operand-sequencer bus: start request in, SRAM read, MAC control and C write strobes out.
interface mmc_operand_sequencer_if #(
    parameter int unsigned CW = 5,
    parameter int unsigned AW = 10
);
    logic          start;
    logic          ren;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [CW-1:0] counter0;
    logic          wr_en_c;
    logic [AW-1:0] addr_c;
    logic          busy;
    logic          done;

    modport master (
        input  start,
        output ren, addr_a, addr_b, counter0, wr_en_c, addr_c, busy, done
    );

    modport slave (
        output start,
        input  ren, addr_a, addr_b, counter0, wr_en_c, addr_c, busy, done
    );
endinterface

// File: rtl/mmc_operand_sequencer.sv
// Walks the (i, j, k) loop nest of an NxN matrix product and issues SRAM reads,
// MAC accumulate-restart marks and C-memory write strobes in a 3-stage pipeline.
module mmc_operand_sequencer #(
    parameter int unsigned N  = 32,
    parameter int unsigned CW = 5,
    parameter int unsigned AW = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    mmc_operand_sequencer_if.master io_seq
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [CW-1:0] IdxMax = CW'(N - 1);

    state_e        r_state, w_state_next;
    logic [CW-1:0] r_i, r_j, r_k;
    logic [CW-1:0] w_i_next, w_j_next, w_k_next;
    logic          r_drain_cnt, w_drain_cnt_next;

    logic          r_v1;
    logic [CW-1:0] r_i1, r_j1, r_k1;
    logic          r_wr;
    logic [AW-1:0] r_addr_c;

    logic          w_ren;
    logic          w_last;
    logic          w_dot_end;

    assign w_ren     = (r_state == StRun);
    assign w_last    = (r_i == IdxMax) && (r_j == IdxMax) && (r_k == IdxMax);
    assign w_dot_end = r_v1 && (r_k1 == IdxMax);

    always_comb begin
        w_state_next     = r_state;
        w_i_next         = r_i;
        w_j_next         = r_j;
        w_k_next         = r_k;
        w_drain_cnt_next = r_drain_cnt;
        unique case (r_state)
            StIdle: begin
                if (io_seq.start) begin
                    w_state_next = StRun;
                    w_i_next     = '0;
                    w_j_next     = '0;
                    w_k_next     = '0;
                end
            end
            StRun: begin
                // Indices freeze on the final address so addr_a/addr_b hold afterwards.
                if (w_last) begin
                    w_state_next     = StDrain;
                    w_drain_cnt_next = 1'b0;
                end else begin
                    w_k_next = r_k + CW'(1);
                    if (r_k == IdxMax) begin
                        w_j_next = r_j + CW'(1);
                        if (r_j == IdxMax) begin
                            w_i_next = r_i + CW'(1);
                        end
                    end
                end
            end
            StDrain: begin
                w_drain_cnt_next = 1'b1;
                if (r_drain_cnt) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_drain_cnt <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_i         <= w_i_next;
            r_j         <= w_j_next;
            r_k         <= w_k_next;
            r_drain_cnt <= w_drain_cnt_next;
        end
    end

    // Stage 1 tracks the index whose operands are on DO_A/DO_B; stage 2 the MAC result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v1     <= 1'b0;
            r_i1     <= '0;
            r_j1     <= '0;
            r_k1     <= '0;
            r_wr     <= 1'b0;
            r_addr_c <= '0;
        end else begin
            r_v1 <= w_ren;
            r_i1 <= r_i;
            r_j1 <= r_j;
            r_k1 <= r_k;
            r_wr <= w_dot_end;
            if (w_dot_end) begin
                r_addr_c <= {r_i1, r_j1};
            end
        end
    end

    assign io_seq.ren      = w_ren;
    assign io_seq.addr_a   = {r_i, r_k};
    assign io_seq.addr_b   = {r_k, r_j};
    assign io_seq.counter0 = r_v1 ? (r_k1 + CW'(1)) : '0;
    assign io_seq.wr_en_c  = r_wr;
    assign io_seq.addr_c   = r_addr_c;
    assign io_seq.busy     = (r_state != StIdle);
    assign io_seq.done     = (r_state == StDone);

endmodule
